tff_down_counter: RTL and testbench
===================================

# tff_down_counter

Synchronous, loadable WIDTH-bit down-counter with a terminal-count pulse. It counts in the opposite direction to the team's ripple up-counter. It is the timeout/interval source for blocks that need "N enabled cycles, then an event". All state bits share one clock, so the count never shows ripple intermediate values. Each bit is a toggle stage driven by a borrow chain.

## Interface
- WIDTH, 6, counter width in bits; legal range 2..16.

- clk  input  1  sole clock; all state changes on the rising edge.
- clr  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- load  input  1  load strobe; captures load_val on the next rising edge.
- load_val  input  WIDTH  start value for the count.
- en  input  1  count enable; one decrement per edge while running.
- count  output  WIDTH  current count, registered.
- busy  output  1  high while a count is in progress (RUN state), registered.
- tc  output  1  terminal-count pulse, registered; high for exactly one cycle.
- zero  output  1  combinational, equal to (count == 0).

## Operation
- States: IDLE (busy=0) and RUN (busy=1). busy is the state register.
- Priority at each rising edge is clr, then load, then en.
- clr=1:
  - count=0, busy=0, tc=0, reload register=0.
  - Load and en are ignored.
  - Takes effect mid-run, with no tc.
- load=1 (any state):
  - count<=load_val; tc<=0.
  - busy<=(load_val != 0).
  - A load during RUN restarts the count; the old count is discarded and no tc is produced.
  - load_val=0 leaves the block in IDLE with count=0.
- RUN, en=1, no load:
  - Bit i toggles when en & busy and bits [i-1:0] are all 0. Bit 0 always toggles.
  - The result equals count-1.
- RUN, en=1, count==1 (terminal edge):
  - count<=0, busy<=0, tc<=1.
- en=0: count, busy and state hold; tc<=0.
- IDLE, en=1: count holds. No wrap from 0 to 2^WIDTH-1 and no tc.
- tc<=0 on every edge that is not a terminal edge.
- Arithmetic is unsigned modulo 2^WIDTH. Underflow is impossible because decrement only occurs with count>=1.

## Timing
- Load latency is 1 cycle: count and busy are valid on the edge that samples load.
- For a load of N (N>=1) with en held high, count reads N, N-1, …, 1 on successive cycles.
  - On the Nth enabled edge after the load edge, count=0, busy=0 and tc=1 all assert together.
  - tc deasserts on the following edge.
- Gaps in en stretch the sequence one cycle per low-en cycle. tc still fires on exactly the Nth enabled edge.
- zero tracks count in the same cycle with no register delay.
- Outputs after reset: count=0, busy=0, tc=0, zero=1.

## Configuration
- TFF_DOWN_COUNTER_AUTO_RELOAD_EN
  - Defined:
    - A WIDTH-bit reload register captures load_val on every load edge.
    - On a terminal edge: count<=reload, busy stays 1, tc<=1.
    - The counter then runs periodically with period N enabled cycles until the next load or clr.
    - A load of 0 still goes to IDLE.
  - Undefined:
    - No reload register.
    - One-shot behaviour as described in Operation.

## Test plan
- Reset: assert clr for 2 cycles with load=1, load_val=9, en=1 → count=0, busy=0, tc=0, zero=1 after each edge.
- One-shot: load 5, then en=1 continuously → count 5,4,3,2,1,0. busy falls and tc=1 in the same cycle count reaches 0. tc=0 on the next cycle. count holds at 0 for 10 more enabled cycles.
- Enable gaps and load 0:
  - Load 3, with en pattern 1,0,0,1,1 → count 3,2,2,2,1,0, tc on the 5th edge only.
  - Load 0 → busy=0, tc never asserts.
- Mid-run events:
  - Load 20, count to 17, then load 4 → count=4 next cycle, no tc, tc after 4 more enabled edges.
  - Load 20, then clr mid-run → count=0 and no tc.
- Borrow chain and simultaneous load: with WIDTH=6, load 32 with en=1 → next count=31 (all lower bits toggle on one edge). Assert load and en together at 31 with load_val=7 → count=7 (load wins).
- Auto-reload (macro defined): load 3, en=1 for 9 cycles → count 3,2,1,3,2,1,3,2,1, tc on every 3rd edge, busy constantly 1. Undefined build, same stimulus → single tc, then count=0.

Source files
------------

// File: rtl/tff_down_counter_if.sv
// Signal bundle for tff_down_counter: load/enable controls in, count status out.
// master drives load/load_val/en; slave (the counter) drives count/busy/tc/zero.
interface tff_down_counter_if #(
    parameter int WIDTH = 6
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             zero;

    modport master (
        output load, load_val, en,
        input  count, busy, tc, zero
    );

    modport slave (
        input  load, load_val, en,
        output count, busy, tc, zero
    );
endinterface

// File: rtl/tff_down_counter.sv
// Loadable synchronous down-counter built from toggle stages on a borrow chain,
// with a one-cycle terminal-count pulse. Define TFF_DOWN_COUNTER_AUTO_RELOAD_EN for periodic reload.
module tff_down_counter #(
    parameter int WIDTH = 6
) (
    input  logic                clk,
    input  logic                clr,
    tff_down_counter_if.slave   bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] toggle;
    logic             tc_q;
    logic             step;
    logic             terminal;
    logic             borrow;

`ifdef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
`endif

    assign step     = bus.en && (state_q == RUN);
    assign terminal = step && (count_q == WIDTH'(1));

    // Bit i toggles only while every lower bit is zero, which yields count-1.
    always_comb begin
        borrow = step;
        toggle = '0;
        for (int i = 0; i < WIDTH; i++) begin
            toggle[i] = borrow;
            borrow    = borrow & ~count_q[i];
        end
        count_d = count_q ^ toggle;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q  <= '0;
            state_q  <= IDLE;
            tc_q     <= 1'b0;
`ifdef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else if (bus.load) begin
            count_q  <= bus.load_val;
            state_q  <= (bus.load_val != '0) ? RUN : IDLE;
            tc_q     <= 1'b0;
`ifdef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
            reload_q <= bus.load_val;
`endif
        end else if (terminal) begin
            tc_q    <= 1'b1;
`ifdef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
            count_q <= reload_q;
            state_q <= RUN;
`else
            count_q <= '0;
            state_q <= IDLE;
`endif
        end else begin
            count_q <= count_d;
            tc_q    <= 1'b0;
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = (state_q == RUN);
    assign bus.tc    = tc_q;
    assign bus.zero  = (count_q == '0);
endmodule

// File: tb/tb_tff_down_counter.sv
// Directed-vector bench for tff_down_counter; expectations follow the one-shot
// or auto-reload behaviour depending on TFF_DOWN_COUNTER_AUTO_RELOAD_EN.
module tb_tff_down_counter;
    localparam int WIDTH = 6;
`ifdef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr;
    int   tests_run    = 0;
    int   tests_failed = 0;

    tff_down_counter_if #(.WIDTH(WIDTH)) bus ();

    tff_down_counter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then check every output #1 after the edge.
    task automatic step(input string tag, input bit c, input bit ld, input int v, input bit e,
                        input int ec, input bit eb, input bit et);
        clr          = c;
        bus.load     = ld;
        bus.load_val = WIDTH'(v);
        bus.en       = e;
        @(posedge clk);
        #1;
        check({tag, ".count"}, 32'(bus.count), 32'(ec));
        check({tag, ".busy"},  32'(bus.busy),  32'(eb));
        check({tag, ".tc"},    32'(bus.tc),    32'(et));
        check({tag, ".zero"},  32'(bus.zero),  32'(ec == 0));
    endtask

    initial begin
        clr          = 1'b1;
        bus.load     = 1'b1;
        bus.load_val = WIDTH'(9);
        bus.en       = 1'b1;

        // Reset dominates load and en.
        step("rst0", 1, 1, 9, 1, 0, 0, 0);
        step("rst1", 1, 1, 9, 1, 0, 0, 0);

        // One-shot from 5.
        step("os_ld", 0, 1, 5, 1, 5, 1, 0);
        step("os4",   0, 0, 0, 1, 4, 1, 0);
        step("os3",   0, 0, 0, 1, 3, 1, 0);
        step("os2",   0, 0, 0, 1, 2, 1, 0);
        step("os1",   0, 0, 0, 1, 1, 1, 0);
        step("os_tc", 0, 0, 0, 1, AR ? 5 : 0, AR, 1);
        step("os_l0", 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step("os_hold", 0, 0, 0, 1, 0, 0, 0);

        // Enable gaps.
        step("gap_ld", 0, 1, 3, 1, 3, 1, 0);
        step("gap_e1", 0, 0, 0, 1, 2, 1, 0);
        step("gap_e0", 0, 0, 0, 0, 2, 1, 0);
        step("gap_e0", 0, 0, 0, 0, 2, 1, 0);
        step("gap_e1", 0, 0, 0, 1, 1, 1, 0);
        step("gap_tc", 0, 0, 0, 1, AR ? 3 : 0, AR, 1);
        step("gap_l0", 0, 1, 0, 0, 0, 0, 0);

        // Load of zero stays idle.
        step("z_ld", 0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("z_run", 0, 0, 0, 1, 0, 0, 0);

        // Reload mid-run discards old count.
        step("mr_ld20", 0, 1, 20, 1, 20, 1, 0);
        step("mr19",    0, 0, 0,  1, 19, 1, 0);
        step("mr18",    0, 0, 0,  1, 18, 1, 0);
        step("mr17",    0, 0, 0,  1, 17, 1, 0);
        step("mr_ld4",  0, 1, 4,  1, 4,  1, 0);
        step("mr3",     0, 0, 0,  1, 3,  1, 0);
        step("mr2",     0, 0, 0,  1, 2,  1, 0);
        step("mr1",     0, 0, 0,  1, 1,  1, 0);
        step("mr_tc",   0, 0, 0,  1, AR ? 4 : 0, AR, 1);
        step("mr_l0",   0, 1, 0,  0, 0,  0, 0);

        // Clear mid-run.
        step("cl_ld20", 0, 1, 20, 1, 20, 1, 0);
        step("cl19",    0, 0, 0,  1, 19, 1, 0);
        step("cl_clr",  1, 0, 0,  1, 0,  0, 0);
        step("cl_post", 0, 0, 0,  1, 0,  0, 0);

        // Borrow chain across many bits, and load beating en.
        step("bc_ld32", 0, 1, 32, 1, 32, 1, 0);
        step("bc31",    0, 0, 0,  1, 31, 1, 0);
        step("bc_ld7",  0, 1, 7,  1, 7,  1, 0);
        step("bc6",     0, 0, 0,  1, 6,  1, 0);
        step("bc_ld63", 0, 1, 63, 0, 63, 1, 0);
        step("bc62",    0, 0, 0,  1, 62, 1, 0);
        step("bc_ld16", 0, 1, 16, 0, 16, 1, 0);
        step("bc15",    0, 0, 0,  1, 15, 1, 0);
        step("bc_l0",   0, 1, 0,  0, 0,  0, 0);

        // Periodic vs one-shot with load 3.
        step("ar_ld3", 0, 1, 3, 1, 3, 1, 0);
`ifdef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
        for (int k = 0; k < 2; k++) begin
            step("ar2",  0, 0, 0, 1, 2, 1, 0);
            step("ar1",  0, 0, 0, 1, 1, 1, 0);
            step("ar_tc", 0, 0, 0, 1, 3, 1, 1);
        end
        step("ar2", 0, 0, 0, 1, 2, 1, 0);
        step("ar1", 0, 0, 0, 1, 1, 1, 0);
        // Clear wipes the reload value too.
        step("ar_clr",  1, 0, 0, 1, 0, 0, 0);
        step("ar_idle", 0, 0, 0, 1, 0, 0, 0);
`else
        step("ar2",   0, 0, 0, 1, 2, 1, 0);
        step("ar1",   0, 0, 0, 1, 1, 1, 0);
        step("ar_tc", 0, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) step("ar_hold", 0, 0, 0, 1, 0, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
